// File: rtl/npu_dma_pkg.sv
// Shared widths, FSM encoding and burst sizing helper for the TinyNPU SDRAM DMA masters.
package npu_dma_pkg;

   localparam int unsigned ADDR_W_DEF = 28;
   localparam int unsigned DATA_W_DEF = 128;
   localparam int unsigned BCNT_W     = 8;
   localparam int unsigned LEN_W      = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   function automatic logic [BCNT_W-1:0] burst_size(input logic [LEN_W-1:0] left,
                                                   input int unsigned       bmax);
      if (32'(left) >= bmax) return BCNT_W'(bmax);
      return left[BCNT_W-1:0];
   endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on o_rd_data while not empty.
module npu_sync_fifo #(
   parameter int unsigned WIDTH = 128,
   parameter int unsigned DEPTH = 64
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_wr_en,
   input  logic [WIDTH-1:0]       i_wr_data,
   input  logic                   i_rd_en,
   output logic [WIDTH-1:0]       o_rd_data,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_wr;
   logic             w_rd;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == (AW+1)'(DEPTH));
   assign w_wr      = i_wr_en & ~w_full;
   assign w_rd      = i_rd_en & ~o_empty;
   assign o_count   = r_count;
   // Force zero when empty so the stream data bus is clean out of reset.
   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/npu_sdram_burst_reader.sv
// Avalon-MM burst read master for the f2h_sdram0 port: splits one read command into
// bursts, limits outstanding reads to FIFO space and streams the beats out with a last marker.
//
// state | meaning
// IDLE  | waiting for a command (cmd_ready=1)
// ISSUE | issuing bursts until every beat of the command has been requested
// DRAIN | all bursts accepted; streaming the remaining beats out
module npu_sdram_burst_reader
   import npu_dma_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned BURST_MAX  = 16,
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] avm_address,
   output logic [BCNT_W-1:0] avm_burstcount,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned SW = CW + 1;

   rd_state_t         r_state;
   rd_state_t         w_state_nxt;
   logic [ADDR_W-1:0] r_req_addr;
   logic [ADDR_W-1:0] w_addr_after;
   logic [LEN_W-1:0]  r_req_left;
   logic [LEN_W-1:0]  w_left_after;
   logic [LEN_W-1:0]  r_rsp_left;
   logic [LEN_W-1:0]  w_rsp_left_nxt;
   logic [CW-1:0]     r_outstanding;
   logic [CW-1:0]     w_outstanding_nxt;
   logic [CW-1:0]     w_fifo_count;
   logic              r_avm_read;
   logic              w_avm_read_nxt;
   logic [ADDR_W-1:0] r_avm_address;
   logic [BCNT_W-1:0] r_avm_burstcount;
   logic              r_cmd_ready;
   logic              r_done;
   logic              w_done_nxt;
   logic              r_err;
   logic              w_cmd_fire;
   logic              w_accept;
   logic              w_hold;
   logic              w_rdv_ok;
   logic              w_rdv_drop;
   logic              w_pop;
   logic              w_fifo_empty;
   logic [BCNT_W-1:0] w_b_next;
   logic [SW-1:0]     w_commit_nxt;
   logic              w_space_ok;

   assign w_cmd_fire = cmd_valid & r_cmd_ready;
   assign w_accept   = r_avm_read & ~avm_waitrequest;
   assign w_hold     = r_avm_read & avm_waitrequest;
   assign w_rdv_ok   = avm_readdatavalid & (r_outstanding != '0);
   assign w_rdv_drop = avm_readdatavalid & (r_outstanding == '0);
   assign w_pop      = ~w_fifo_empty & out_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_addr_after   = r_req_addr;
      w_left_after   = r_req_left;
      w_rsp_left_nxt = r_rsp_left;
      w_done_nxt     = 1'b0;
      if (w_accept) begin
         w_addr_after = r_req_addr + ADDR_W'(r_avm_burstcount);
         w_left_after = r_req_left - LEN_W'(r_avm_burstcount);
      end
      if (w_pop) w_rsp_left_nxt = r_rsp_left - LEN_W'(1);
      case (r_state)
         IDLE: begin
            if (w_cmd_fire) begin
               w_addr_after   = cmd_addr;
               w_left_after   = cmd_len;
               w_rsp_left_nxt = cmd_len;
               if (cmd_len == '0) w_done_nxt  = 1'b1;
               else               w_state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (w_left_after == '0) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_pop && (r_rsp_left == LEN_W'(1))) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Next-cycle request decision uses post-edge totals so bursts can go back to back.
   // Beats moving from outstanding into the FIFO leave the committed total unchanged.
   always_comb begin
      w_outstanding_nxt = r_outstanding
                        + (w_accept ? CW'(r_avm_burstcount) : '0)
                        - (w_rdv_ok ? CW'(1) : '0);
      w_commit_nxt      = SW'(w_fifo_count) + SW'(r_outstanding)
                        + (w_accept ? SW'(r_avm_burstcount) : '0)
                        - (w_pop ? SW'(1) : '0);
      w_b_next          = burst_size(w_left_after, BURST_MAX);
      w_space_ok        = (w_commit_nxt + SW'(w_b_next)) <= SW'(FIFO_DEPTH);
      w_avm_read_nxt    = w_hold |
                          ((w_state_nxt == ISSUE) && (w_left_after != '0) && w_space_ok);
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state          <= IDLE;
         r_req_addr       <= '0;
         r_req_left       <= '0;
         r_rsp_left       <= '0;
         r_outstanding    <= '0;
         r_avm_read       <= 1'b0;
         r_avm_address    <= '0;
         r_avm_burstcount <= '0;
         r_cmd_ready      <= 1'b0;
         r_done           <= 1'b0;
         r_err            <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_req_addr    <= w_addr_after;
         r_req_left    <= w_left_after;
         r_rsp_left    <= w_rsp_left_nxt;
         r_outstanding <= w_outstanding_nxt;
         r_avm_read    <= w_avm_read_nxt;
         if (w_avm_read_nxt && !w_hold) begin
            r_avm_address    <= w_addr_after;
            r_avm_burstcount <= w_b_next;
         end
         r_cmd_ready <= (w_state_nxt == IDLE);
         r_done      <= w_done_nxt;
         if (w_rdv_drop) r_err <= 1'b1;
      end
   end

   npu_sync_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk     (clk_clk),
      .i_rst     (reset_reset),
      .i_wr_en   (w_rdv_ok),
      .i_wr_data (avm_readdata),
      .i_rd_en   (out_ready),
      .o_rd_data (out_data),
      .o_empty   (w_fifo_empty),
      .o_count   (w_fifo_count)
   );

   assign cmd_ready      = r_cmd_ready;
   assign busy           = (r_state != IDLE);
   assign done           = r_done;
   assign err            = r_err;
   assign avm_read       = r_avm_read;
   assign avm_address    = r_avm_address;
   assign avm_burstcount = r_avm_burstcount;
   assign out_valid      = ~w_fifo_empty;
   assign out_last       = ~w_fifo_empty & (r_rsp_left == LEN_W'(1));

endmodule

// File: tb/tb_npu_sdram_burst_reader.sv
// Directed bench for npu_sdram_burst_reader: command vector table plus hand-written
// sequences for backpressure, spurious responses and asynchronous reset.
module tb_npu_sdram_burst_reader;

   logic          clk_clk = 1'b0;
   logic          reset_reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [27:0]   cmd_addr;
   logic [15:0]   cmd_len;
   logic          busy;
   logic          done;
   logic          err;
   logic [27:0]   avm_address;
   logic [7:0]    avm_burstcount;
   logic          avm_read;
   logic          avm_waitrequest;
   logic [127:0]  avm_readdata;
   logic          avm_readdatavalid;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_data;
   logic          out_last;

   npu_sdram_burst_reader #(
      .ADDR_W     (28),
      .DATA_W     (128),
      .BURST_MAX  (16),
      .FIFO_DEPTH (64)
   ) dut (
      .clk_clk           (clk_clk),
      .reset_reset       (reset_reset),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_addr          (cmd_addr),
      .cmd_len           (cmd_len),
      .busy              (busy),
      .done              (done),
      .err               (err),
      .avm_address       (avm_address),
      .avm_burstcount    (avm_burstcount),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .out_last          (out_last)
   );

   always #5 clk_clk = ~clk_clk;

   typedef struct {
      logic [27:0] addr;
      int          len;
      int          stall;
      int          nb;
      logic [27:0] ba [3];
      logic [7:0]  bc [3];
      int          lat;
   } vec_t;

   vec_t vecs [7];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_n    = 0;

   logic [27:0] q_pend [$];
   logic [27:0] bq_addr [$];
   logic [7:0]  bq_cnt [$];

   logic [27:0] cur_addr;
   int          cur_len;
   int          beat_idx;
   int          done_cnt;
   int          done_cyc;
   int          last_pop_cyc;
   int          hs_cyc;
   int          first_read_cyc;
   int          acc_beats;
   int          stall_target;
   int          stall_cnt;
   logic        prev_stall;
   logic [27:0] held_addr;
   logic [7:0]  held_bc;

   function automatic logic [127:0] pat(input logic [27:0] a);
      return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   // Observes the handshakes of the cycle that is about to end.
   task automatic monitor();
      if (cmd_valid && cmd_ready) hs_cyc = cyc_n;
      if (avm_read && first_read_cyc < 0) first_read_cyc = cyc_n;
      if (prev_stall) begin
         chk("hold_read", {127'd0, avm_read}, 128'd1);
         chk("hold_addr", {100'd0, avm_address}, {100'd0, held_addr});
         chk("hold_bcnt", {120'd0, avm_burstcount}, {120'd0, held_bc});
      end
      prev_stall = avm_read && avm_waitrequest;
      held_addr  = avm_address;
      held_bc    = avm_burstcount;
      if (avm_read && !avm_waitrequest) begin
         bq_addr.push_back(avm_address);
         bq_cnt.push_back(avm_burstcount);
         for (int k = 0; k < int'(avm_burstcount); k++) q_pend.push_back(avm_address + 28'(k));
         acc_beats += int'(avm_burstcount);
      end
      if (out_valid && out_ready) begin
         chk("beat_data", out_data, pat(cur_addr + 28'(beat_idx)));
         chk("beat_last", {127'd0, out_last}, {127'd0, (beat_idx == cur_len - 1)});
         if (beat_idx == cur_len - 1) last_pop_cyc = cyc_n;
         beat_idx++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc_n;
      end
   endtask

   // Zero-wait slave with read latency 1; optional 5-cycle stall on one burst index.
   task automatic slave_drive();
      avm_waitrequest = 1'b0;
      if (avm_read && stall_target >= 0 && bq_addr.size() == stall_target && stall_cnt < 5) begin
         avm_waitrequest = 1'b1;
         stall_cnt++;
      end
      if (q_pend.size() > 0) begin
         avm_readdatavalid = 1'b1;
         avm_readdata      = pat(q_pend.pop_front());
      end else begin
         avm_readdatavalid = 1'b0;
         avm_readdata      = '0;
      end
   endtask

   task automatic cyc();
      monitor();
      @(posedge clk_clk);
      #1;
      cyc_n++;
      slave_drive();
   endtask

   task automatic setup_cmd(input logic [27:0] a, input int len, input int stall);
      cur_addr       = a;
      cur_len        = len;
      beat_idx       = 0;
      done_cnt       = 0;
      done_cyc       = -1;
      last_pop_cyc   = -1;
      hs_cyc         = -1;
      first_read_cyc = -1;
      acc_beats      = 0;
      stall_target   = stall;
      stall_cnt      = 0;
      prev_stall     = 1'b0;
      bq_addr.delete();
      bq_cnt.delete();
   endtask

   task automatic issue_cmd();
      int n = 0;
      while (!cmd_ready && n < 20) begin
         cyc();
         n++;
      end
      cmd_addr  = cur_addr;
      cmd_len   = 16'(cur_len);
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == 0 && n < 3000) begin
         cyc();
         n++;
      end
      repeat (3) cyc();
   endtask

   task automatic set_vec(input int i, input logic [27:0] a, input int len, input int stall,
                          input int nb, input logic [27:0] a0, input logic [7:0] c0,
                          input logic [27:0] a1, input logic [7:0] c1,
                          input logic [27:0] a2, input logic [7:0] c2, input int lat);
      vecs[i].addr  = a;
      vecs[i].len   = len;
      vecs[i].stall = stall;
      vecs[i].nb    = nb;
      vecs[i].ba[0] = a0;
      vecs[i].bc[0] = c0;
      vecs[i].ba[1] = a1;
      vecs[i].bc[1] = c1;
      vecs[i].ba[2] = a2;
      vecs[i].bc[2] = c2;
      vecs[i].lat   = lat;
   endtask

   task automatic run_vec(input int i);
      setup_cmd(vecs[i].addr, vecs[i].len, vecs[i].stall);
      issue_cmd();
      wait_done();
      chk("done_count", 128'(done_cnt), 128'd1);
      chk("beats_out", 128'(beat_idx), 128'(vecs[i].len));
      chk("cmd_to_done", 128'(done_cyc - hs_cyc), 128'(vecs[i].lat));
      if (vecs[i].len == 0) begin
         chk("no_read_len0", 128'(first_read_cyc), 128'(-1));
      end else begin
         chk("first_read_lat", 128'(first_read_cyc - hs_cyc), 128'd1);
         chk("done_after_last", 128'(done_cyc - last_pop_cyc), 128'd1);
      end
      chk("n_bursts", 128'(bq_addr.size()), 128'(vecs[i].nb));
      for (int b = 0; b < vecs[i].nb; b++) begin
         chk("burst_addr", (b < bq_addr.size()) ? {100'd0, bq_addr[b]} : '1, {100'd0, vecs[i].ba[b]});
         chk("burst_cnt", (b < bq_cnt.size()) ? {120'd0, bq_cnt[b]} : '1, {120'd0, vecs[i].bc[b]});
      end
      if (vecs[i].stall >= 0) chk("stall_cycles", 128'(stall_cnt), 128'd5);
      chk("busy_idle", {127'd0, busy}, 128'd0);
      chk("cmd_ready_idle", {127'd0, cmd_ready}, 128'd1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_cmd_ready", {127'd0, cmd_ready}, 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_done", {127'd0, done}, 128'd0);
      chk("rst_err", {127'd0, err}, 128'd0);
      chk("rst_avm_read", {127'd0, avm_read}, 128'd0);
      chk("rst_avm_address", {100'd0, avm_address}, 128'd0);
      chk("rst_avm_bcnt", {120'd0, avm_burstcount}, 128'd0);
      chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
      chk("rst_out_last", {127'd0, out_last}, 128'd0);
      chk("rst_out_data", out_data, 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before the test sequence completed");
      $fatal(1, "watchdog");
   end

   initial begin
      set_vec(0, 28'h0000100, 40, -1, 3, 28'h0000100, 8'd16, 28'h0000110, 8'd16, 28'h0000120, 8'd8, 43);
      set_vec(1, 28'h0000100, 40,  1, 3, 28'h0000100, 8'd16, 28'h0000110, 8'd16, 28'h0000120, 8'd8, 43);
      set_vec(2, 28'hFFFFFF8, 24, -1, 2, 28'hFFFFFF8, 8'd16, 28'h0000008, 8'd8,  28'h0,      8'd0, 27);
      set_vec(3, 28'h0000005,  1, -1, 1, 28'h0000005, 8'd1,  28'h0,      8'd0,  28'h0,      8'd0, 4);
      set_vec(4, 28'h0000200, 16, -1, 1, 28'h0000200, 8'd16, 28'h0,      8'd0,  28'h0,      8'd0, 19);
      set_vec(5, 28'h0000300, 17, -1, 2, 28'h0000300, 8'd16, 28'h0000310, 8'd1,  28'h0,      8'd0, 20);
      set_vec(6, 28'h0000777,  0, -1, 0, 28'h0,       8'd0,  28'h0,      8'd0,  28'h0,      8'd0, 1);

      reset_reset       = 1'b1;
      cmd_valid         = 1'b0;
      cmd_addr          = '0;
      cmd_len           = '0;
      avm_waitrequest   = 1'b0;
      avm_readdata      = '0;
      avm_readdatavalid = 1'b0;
      out_ready         = 1'b1;
      setup_cmd(28'h0, 0, -1);

      repeat (3) @(posedge clk_clk);
      #1;
      chk_reset_outputs();
      reset_reset = 1'b0;
      cyc();
      chk("cmd_ready_after_rst", {127'd0, cmd_ready}, 128'd1);

      for (int i = 0; i < 7; i++) run_vec(i);

      // Consumer stalled: requests must stop at the FIFO depth until the stream drains.
      setup_cmd(28'h0000400, 100, -1);
      out_ready = 1'b0;
      issue_cmd();
      repeat (80) cyc();
      chk("bp_requested", 128'(acc_beats), 128'd64);
      chk("bp_read_idle", {127'd0, avm_read}, 128'd0);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      chk("bp_no_beats", 128'(beat_idx), 128'd0);
      out_ready = 1'b1;
      wait_done();
      chk("bp_beats_out", 128'(beat_idx), 128'd100);
      chk("bp_requested_all", 128'(acc_beats), 128'd100);
      chk("bp_done_count", 128'(done_cnt), 128'd1);

      // Spurious response while idle.
      setup_cmd(28'h0, 0, -1);
      cyc();
      avm_readdatavalid = 1'b1;
      avm_readdata      = '1;
      cyc();
      chk("spur_err", {127'd0, err}, 128'd1);
      chk("spur_no_valid", {127'd0, out_valid}, 128'd0);
      cyc();
      chk("spur_err_sticky", {127'd0, err}, 128'd1);
      chk("spur_no_valid2", {127'd0, out_valid}, 128'd0);

      // Asynchronous reset in the middle of a command.
      setup_cmd(28'h0000100, 40, -1);
      issue_cmd();
      repeat (4) cyc();
      chk("mid_busy", {127'd0, busy}, 128'd1);
      reset_reset = 1'b1;
      #2;
      chk_reset_outputs();
      q_pend.delete();
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      avm_waitrequest   = 1'b0;
      setup_cmd(28'h0, 0, -1);
      repeat (2) cyc();
      q_pend.delete();
      reset_reset = 1'b0;
      cyc();
      chk("cmd_ready_after_rst2", {127'd0, cmd_ready}, 128'd1);
      run_vec(0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
